spi_bus_arbiter: RTL and testbench
==================================

Name: spi_bus_arbiter

Overview:
- Shares the single spi_core transaction interface and the SPI chip-select lines between two requesters.
  - Port 0: mem_ctrl (flash/RAM fetches).
  - Port 1: the register-space SPI peripheral at 0xFF00+.
- Grants whole multi-byte bursts: the owner holds the bus, and its chip selects, until it drops its request and its last byte completes.
- Enforces a minimum all-CS-high gap between owners.
- Flags protocol violations.

Parameters:
- NUM_CS, 2, number of active-low chip selects (bit 0 flash, bit 1 RAM, higher bits external).
- CS_GAP, 2, minimum cycles all CS high between two grants (1..15).
- FIXED_PRIORITY, 0, 0 = round-robin; 1 = port 0 always wins ties.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- m0_req  in  1  port 0 requests/holds the bus
- m0_gnt  out  1  port 0 owns the bus
- m0_data_tx  in  8  byte to shift out
- m0_txn_start  in  1  one-cycle start pulse
- m0_force_clock  in  1  passed to spi_core when owner
- m0_cs_n  in  NUM_CS  requested chip selects
- m0_data_rx  out  8  received byte
- m0_txn_done  out  1  done pulse, owner only
- m1_* : identical set for port 1
- spi_data_tx  out  8  to spi_core
- spi_txn_start  out  1  to spi_core
- spi_force_clock  out  1  to spi_core
- spi_data_rx  in  8  from spi_core
- spi_txn_done  in  1  from spi_core
- spi_cs_n  out  NUM_CS  chip selects to pads
- protocol_err  out  1  sticky violation flag
- err_clr  in  1  clears protocol_err

Behaviour:
- State register: IDLE, OWN0, OWN1, GAP. Gap counter is 4 bits; busy flag tracks a transaction in flight; last_owner is 1 bit.
- Reset values:
  - state = GAP, gap counter = CS_GAP, busy = 0, last_owner = 1 (port 0 served first).
  - All outputs: gnt = 0, spi_cs_n = all ones, spi_txn_start = 0, spi_force_clock = 0, spi_data_tx = 0, m*_txn_done = 0, protocol_err = 0.
- Outputs are combinational from registered state:
  - m0_gnt = (state == OWN0); m1_gnt = (state == OWN1).
  - In OWNx, spi_data_tx, spi_force_clock and spi_cs_n come from port x, and spi_txn_start = mx_txn_start.
  - Otherwise tx = 0, force = 0, cs all ones, start = 0.
  - m*_data_rx = spi_data_rx on both ports. mx_txn_done = spi_txn_done & (state == OWNx).
- IDLE:
  - Only m0_req -> OWN0. Only m1_req -> OWN1.
  - Both requesting: with round-robin, the port != last_owner wins; with FIXED_PRIORITY, port 0 wins.
  - Latency: req sampled at edge N, gnt high from cycle N+1. The owner's first txn_start is accepted on the cycle gnt is high.
- OWNx:
  - busy is set on a forwarded txn_start and cleared on spi_txn_done.
  - If start and done occur in the same cycle, busy stays set.
  - Exit when req_x = 0, busy = 0 and no txn_start this cycle: go to GAP, load counter = CS_GAP, last_owner = x.
  - If req drops while busy, or in the same cycle as a start, the grant holds until done, then GAP.
- GAP:
  - Counter decrements each cycle; at 1 -> IDLE. CS stays all high for at least CS_GAP cycles.
  - Requests are not granted in GAP.
- protocol_err is set (sticky) on any of:
  - a non-owner txn_start (the pulse is dropped);
  - owner txn_start while busy and no done this cycle (forwarded anyway);
  - owner cs_n with more than one bit low.
- err_clr clears protocol_err. A set and a clear in the same cycle -> set wins.
- Reset mid-burst: immediate return to reset state and all CS high. spi_core shares rst_n and aborts together with the arbiter.

Decomposition:
- Shared package spi_arb_pkg:
  - state encodings;
  - CS index constants CS_FLASH = 0, CS_RAM = 1;
  - default CS_GAP.
- One natural sub-module, spi_arb_pick: 2-way round-robin/fixed-priority picker (inputs req[1:0], last_owner, FIXED_PRIORITY; output winner). Everything else is inline.

Test Plan:
1. After reset release, m0_req = 1, m0_cs_n = 2'b10 -> spi_cs_n = 2'b11 for 2 cycles (GAP), then m0_gnt = 1 one cycle after IDLE samples req. spi_cs_n = 2'b10.
2. Port 0 owner sends 3 bytes 0x03, 0x00, 0x10 with a start after each done -> spi_data_tx matches each byte. m0_txn_done pulses 3 times. m1_txn_done stays 0.
3. Both req asserted in IDLE repeatedly, each doing 1 byte then releasing -> grants alternate 0, 1, 0, 1 (round-robin). With FIXED_PRIORITY = 1 -> port 0 every time.
4. Owner drops m0_req 1 cycle after txn_start, done returns 8 cycles later -> m0_gnt stays high until the cycle after done. Then GAP of CS_GAP cycles, then m1_gnt.
5. m1_txn_start pulsed while port 0 owns -> spi_txn_start = 0, protocol_err = 1 held; err_clr pulse -> 0. Owner cs_n = 2'b00 -> protocol_err = 1.
6. rst_n low mid-byte while OWN1 with cs 2'b01 -> next cycle spi_cs_n = 2'b11, gnt = 0. After release, GAP then port 0 is favored on a tie.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared definitions for the two-port SPI bus arbiter: FSM encoding,
// chip-select indices and the default inter-owner gap.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_e;

  localparam int CS_FLASH       = 0;
  localparam int CS_RAM         = 1;
  localparam int CS_GAP_DEFAULT = 2;

endpackage

// File: rtl/spi_arb_pick.sv
// Two-way picker: a lone requester wins outright; on a tie the port that was
// not served last wins, unless fixed priority hands it to port 0.
module spi_arb_pick #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       winner
);

  always_comb begin
    winner = 1'b0;
    if (req == 2'b10) begin
      winner = 1'b1;
    end else if (req == 2'b11) begin
      winner = FIXED_PRIORITY ? 1'b0 : ~last_owner;
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one spi_core transaction interface and its chip selects between two
// requesters, granting whole bursts with an enforced all-CS-high gap.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_CS         = 2,
  parameter int CS_GAP         = CS_GAP_DEFAULT,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  output logic              m0_gnt,
  input  logic [7:0]        m0_data_tx,
  input  logic              m0_txn_start,
  input  logic              m0_force_clock,
  input  logic [NUM_CS-1:0] m0_cs_n,
  output logic [7:0]        m0_data_rx,
  output logic              m0_txn_done,
  input  logic              m1_req,
  output logic              m1_gnt,
  input  logic [7:0]        m1_data_tx,
  input  logic              m1_txn_start,
  input  logic              m1_force_clock,
  input  logic [NUM_CS-1:0] m1_cs_n,
  output logic [7:0]        m1_data_rx,
  output logic              m1_txn_done,
  output logic [7:0]        spi_data_tx,
  output logic              spi_txn_start,
  output logic              spi_force_clock,
  input  logic [7:0]        spi_data_rx,
  input  logic              spi_txn_done,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              protocol_err,
  input  logic              err_clr
);

  arb_state_e        state, state_nxt;
  logic [3:0]        gap_cnt, gap_cnt_nxt;
  logic              busy, busy_nxt;
  logic              last_owner, last_owner_nxt;
  logic              err_nxt, err_set;
  logic              winner;
  logic              own0, own1, own_req, fwd_start;
  logic [NUM_CS-1:0] own_cs;

  // True when more than one active-low select is asserted.
  function automatic logic multi_low(input logic [NUM_CS-1:0] cs);
    logic [NUM_CS-1:0] low;
    low = ~cs;
    multi_low = (low & (low - NUM_CS'(1))) != '0;
  endfunction

  spi_arb_pick #(.FIXED_PRIORITY(FIXED_PRIORITY)) u_pick (
    .req        ({m1_req, m0_req}),
    .last_owner (last_owner),
    .winner     (winner)
  );

  always_comb begin
    own0            = (state == ST_OWN0);
    own1            = (state == ST_OWN1);
    m0_gnt          = own0;
    m1_gnt          = own1;
    m0_data_rx      = spi_data_rx;
    m1_data_rx      = spi_data_rx;
    m0_txn_done     = spi_txn_done & own0;
    m1_txn_done     = spi_txn_done & own1;
    spi_data_tx     = '0;
    spi_force_clock = 1'b0;
    spi_cs_n        = '1;
    fwd_start       = 1'b0;
    own_req         = 1'b0;
    own_cs          = '1;
    if (own0) begin
      spi_data_tx     = m0_data_tx;
      spi_force_clock = m0_force_clock;
      spi_cs_n        = m0_cs_n;
      fwd_start       = m0_txn_start;
      own_req         = m0_req;
      own_cs          = m0_cs_n;
    end else if (own1) begin
      spi_data_tx     = m1_data_tx;
      spi_force_clock = m1_force_clock;
      spi_cs_n        = m1_cs_n;
      fwd_start       = m1_txn_start;
      own_req         = m1_req;
      own_cs          = m1_cs_n;
    end
    spi_txn_start = fwd_start;
  end

  always_comb begin
    err_set = (m0_txn_start & ~own0) | (m1_txn_start & ~own1)
            | (fwd_start & busy & ~spi_txn_done)
            | ((own0 | own1) & multi_low(own_cs));
    // A new violation outranks a clear arriving in the same cycle.
    err_nxt = err_set ? 1'b1 : (err_clr ? 1'b0 : protocol_err);
  end

  always_comb begin
    state_nxt      = state;
    gap_cnt_nxt    = gap_cnt;
    busy_nxt       = busy;
    last_owner_nxt = last_owner;
    case (state)
      ST_IDLE: begin
        if (m0_req | m1_req) begin
          state_nxt = winner ? ST_OWN1 : ST_OWN0;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (fwd_start) begin
          busy_nxt = 1'b1;
        end else if (spi_txn_done) begin
          busy_nxt = 1'b0;
        end
        // Release only once the burst is truly finished on the wire.
        if (!own_req && !busy && !fwd_start) begin
          state_nxt      = ST_GAP;
          gap_cnt_nxt    = 4'(CS_GAP);
          last_owner_nxt = own1;
        end
      end
      ST_GAP: begin
        if (gap_cnt <= 4'd1) begin
          state_nxt = ST_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - 4'd1;
        end
      end
      default: state_nxt = ST_GAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_GAP;
      gap_cnt      <= 4'(CS_GAP);
      busy         <= 1'b0;
      last_owner   <= 1'b1;
      protocol_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      gap_cnt      <= gap_cnt_nxt;
      busy         <= busy_nxt;
      last_owner   <= last_owner_nxt;
      protocol_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: a round-robin instance drives most
// scenarios, a fixed-priority instance shares its inputs for the tie test.
module tb_spi_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       m0_req, m0_txn_start, m0_force_clock;
  logic [7:0] m0_data_tx;
  logic [1:0] m0_cs_n;
  logic       m1_req, m1_txn_start, m1_force_clock;
  logic [7:0] m1_data_tx;
  logic [1:0] m1_cs_n;
  logic [7:0] spi_data_rx;
  logic       spi_txn_done, err_clr;

  logic       m0_gnt, m1_gnt, m0_txn_done, m1_txn_done;
  logic [7:0] m0_data_rx, m1_data_rx, spi_data_tx;
  logic       spi_txn_start, spi_force_clock, protocol_err;
  logic [1:0] spi_cs_n;

  logic       fp_m0_gnt, fp_m1_gnt, fp_m0_txn_done, fp_m1_txn_done;
  logic [7:0] fp_m0_data_rx, fp_m1_data_rx, fp_spi_data_tx;
  logic       fp_spi_txn_start, fp_spi_force_clock, fp_protocol_err;
  logic [1:0] fp_spi_cs_n;

  int n_cmp = 0;
  int n_err = 0;

  spi_bus_arbiter #(.NUM_CS(2), .CS_GAP(2), .FIXED_PRIORITY(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_data_tx(m0_data_tx),
    .m0_txn_start(m0_txn_start), .m0_force_clock(m0_force_clock),
    .m0_cs_n(m0_cs_n), .m0_data_rx(m0_data_rx), .m0_txn_done(m0_txn_done),
    .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_data_tx(m1_data_tx),
    .m1_txn_start(m1_txn_start), .m1_force_clock(m1_force_clock),
    .m1_cs_n(m1_cs_n), .m1_data_rx(m1_data_rx), .m1_txn_done(m1_txn_done),
    .spi_data_tx(spi_data_tx), .spi_txn_start(spi_txn_start),
    .spi_force_clock(spi_force_clock), .spi_data_rx(spi_data_rx),
    .spi_txn_done(spi_txn_done), .spi_cs_n(spi_cs_n),
    .protocol_err(protocol_err), .err_clr(err_clr)
  );

  spi_bus_arbiter #(.NUM_CS(2), .CS_GAP(2), .FIXED_PRIORITY(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_gnt(fp_m0_gnt), .m0_data_tx(m0_data_tx),
    .m0_txn_start(m0_txn_start), .m0_force_clock(m0_force_clock),
    .m0_cs_n(m0_cs_n), .m0_data_rx(fp_m0_data_rx), .m0_txn_done(fp_m0_txn_done),
    .m1_req(m1_req), .m1_gnt(fp_m1_gnt), .m1_data_tx(m1_data_tx),
    .m1_txn_start(m1_txn_start), .m1_force_clock(m1_force_clock),
    .m1_cs_n(m1_cs_n), .m1_data_rx(fp_m1_data_rx), .m1_txn_done(fp_m1_txn_done),
    .spi_data_tx(fp_spi_data_tx), .spi_txn_start(fp_spi_txn_start),
    .spi_force_clock(fp_spi_force_clock), .spi_data_rx(spi_data_rx),
    .spi_txn_done(spi_txn_done), .spi_cs_n(fp_spi_cs_n),
    .protocol_err(fp_protocol_err), .err_clr(err_clr)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    m0_req = 1'b0; m0_txn_start = 1'b0; m0_force_clock = 1'b1;
    m0_data_tx = 8'h77; m0_cs_n = 2'b11;
    m1_req = 1'b0; m1_txn_start = 1'b0; m1_force_clock = 1'b1;
    m1_data_tx = 8'h66; m1_cs_n = 2'b11;
    spi_data_rx = 8'h00; spi_txn_done = 1'b0; err_clr = 1'b0;
    step; step;
    n_cmp++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin n_err++; $display("FAIL rst_gnt: got %b%b want 00", m1_gnt, m0_gnt); end
    n_cmp++; if (spi_cs_n !== 2'b11) begin n_err++; $display("FAIL rst_cs: got %b want 11", spi_cs_n); end
    n_cmp++; if (spi_data_tx !== 8'h00) begin n_err++; $display("FAIL rst_tx: got %h want 00", spi_data_tx); end
    n_cmp++; if (spi_force_clock !== 1'b0 || spi_txn_start !== 1'b0) begin n_err++; $display("FAIL rst_force_start: got %b%b want 00", spi_force_clock, spi_txn_start); end
    n_cmp++; if (protocol_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", protocol_err); end
    m0_req = 1'b1; m0_cs_n = 2'b10; rst_n = 1'b1;
    step;
    n_cmp++; if (spi_cs_n !== 2'b11 || m0_gnt !== 1'b0) begin n_err++; $display("FAIL gap1: got cs=%b gnt=%b want cs=11 gnt=0", spi_cs_n, m0_gnt); end
    step;
    n_cmp++; if (spi_cs_n !== 2'b11 || m0_gnt !== 1'b0) begin n_err++; $display("FAIL gap2: got cs=%b gnt=%b want cs=11 gnt=0", spi_cs_n, m0_gnt); end
    step;
    n_cmp++; if (m0_gnt !== 1'b1 || spi_cs_n !== 2'b10) begin n_err++; $display("FAIL first_gnt: got gnt=%b cs=%b want gnt=1 cs=10", m0_gnt, spi_cs_n); end
    n_cmp++; if (spi_force_clock !== 1'b1) begin n_err++; $display("FAIL force_pass: got %b want 1", spi_force_clock); end
  endtask

  task automatic test_burst;
    logic [7:0] bytes [3];
    int done_cnt;
    bytes = '{8'h03, 8'h00, 8'h10};
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      m0_data_tx = bytes[i]; m0_txn_start = 1'b1;
      #1;
      n_cmp++; if (spi_txn_start !== 1'b1 || spi_data_tx !== bytes[i]) begin n_err++; $display("FAIL burst_tx%0d: got start=%b tx=%h want start=1 tx=%h", i, spi_txn_start, spi_data_tx, bytes[i]); end
      step;
      m0_txn_start = 1'b0;
      step; step;
      spi_txn_done = 1'b1; spi_data_rx = bytes[i] ^ 8'hFF;
      #1;
      if (m0_txn_done === 1'b1) done_cnt++;
      n_cmp++; if (m1_txn_done !== 1'b0) begin n_err++; $display("FAIL burst_m1done%0d: got %b want 0", i, m1_txn_done); end
      n_cmp++; if (m0_data_rx !== (bytes[i] ^ 8'hFF)) begin n_err++; $display("FAIL burst_rx%0d: got %h want %h", i, m0_data_rx, bytes[i] ^ 8'hFF); end
      step;
      spi_txn_done = 1'b0;
    end
    n_cmp++; if (done_cnt !== 3) begin n_err++; $display("FAIL burst_done_cnt: got %0d want 3", done_cnt); end
    n_cmp++; if (protocol_err !== 1'b0) begin n_err++; $display("FAIL burst_err: got %b want 0", protocol_err); end
  endtask

  task automatic test_late_release;
    m0_data_tx = 8'h5A; m0_txn_start = 1'b1;
    step;
    m0_txn_start = 1'b0; m0_req = 1'b0; m1_req = 1'b1; m1_cs_n = 2'b01;
    for (int i = 0; i < 7; i++) step;
    n_cmp++; if (m0_gnt !== 1'b1) begin n_err++; $display("FAIL late_hold: got %b want 1", m0_gnt); end
    spi_txn_done = 1'b1;
    step;
    spi_txn_done = 1'b0;
    n_cmp++; if (m0_gnt !== 1'b1) begin n_err++; $display("FAIL late_after_done: got %b want 1", m0_gnt); end
    step;
    n_cmp++; if (m0_gnt !== 1'b0 || spi_cs_n !== 2'b11) begin n_err++; $display("FAIL late_gap1: got gnt=%b cs=%b want gnt=0 cs=11", m0_gnt, spi_cs_n); end
    step;
    n_cmp++; if (m1_gnt !== 1'b0 || spi_cs_n !== 2'b11) begin n_err++; $display("FAIL late_gap2: got gnt=%b cs=%b want gnt=0 cs=11", m1_gnt, spi_cs_n); end
    step;
    n_cmp++; if (m1_gnt !== 1'b0) begin n_err++; $display("FAIL late_idle: got %b want 0", m1_gnt); end
    step;
    n_cmp++; if (m1_gnt !== 1'b1 || spi_cs_n !== 2'b01) begin n_err++; $display("FAIL late_m1_gnt: got gnt=%b cs=%b want gnt=1 cs=01", m1_gnt, spi_cs_n); end
  endtask

  task automatic test_protocol_err;
    m1_req = 1'b0; m0_req = 1'b1; m0_cs_n = 2'b10;
    step; step; step; step;
    n_cmp++; if (m0_gnt !== 1'b1) begin n_err++; $display("FAIL perr_own0: got %b want 1", m0_gnt); end
    m1_txn_start = 1'b1;
    #1;
    n_cmp++; if (spi_txn_start !== 1'b0) begin n_err++; $display("FAIL perr_drop: got %b want 0", spi_txn_start); end
    step;
    m1_txn_start = 1'b0;
    n_cmp++; if (protocol_err !== 1'b1) begin n_err++; $display("FAIL perr_nonowner: got %b want 1", protocol_err); end
    step;
    n_cmp++; if (protocol_err !== 1'b1) begin n_err++; $display("FAIL perr_sticky: got %b want 1", protocol_err); end
    err_clr = 1'b1; step; err_clr = 1'b0;
    n_cmp++; if (protocol_err !== 1'b0) begin n_err++; $display("FAIL perr_clr: got %b want 0", protocol_err); end
    m1_txn_start = 1'b1; err_clr = 1'b1; step; m1_txn_start = 1'b0; err_clr = 1'b0;
    n_cmp++; if (protocol_err !== 1'b1) begin n_err++; $display("FAIL perr_set_wins: got %b want 1", protocol_err); end
    err_clr = 1'b1; step; err_clr = 1'b0;
    m0_cs_n = 2'b00; step; m0_cs_n = 2'b10;
    n_cmp++; if (protocol_err !== 1'b1) begin n_err++; $display("FAIL perr_cs: got %b want 1", protocol_err); end
    err_clr = 1'b1; step; err_clr = 1'b0;
    n_cmp++; if (protocol_err !== 1'b0) begin n_err++; $display("FAIL perr_clr2: got %b want 0", protocol_err); end
    m0_txn_start = 1'b1; step;
    #1;
    n_cmp++; if (spi_txn_start !== 1'b1) begin n_err++; $display("FAIL perr_busy_fwd: got %b want 1", spi_txn_start); end
    step; m0_txn_start = 1'b0;
    n_cmp++; if (protocol_err !== 1'b1) begin n_err++; $display("FAIL perr_busy: got %b want 1", protocol_err); end
    spi_txn_done = 1'b1; step; spi_txn_done = 1'b0;
    err_clr = 1'b1; step; err_clr = 1'b0;
  endtask

  task automatic test_reset_mid_burst;
    m0_req = 1'b0; m1_req = 1'b1; m1_cs_n = 2'b01;
    step; step; step; step;
    n_cmp++; if (m1_gnt !== 1'b1 || spi_cs_n !== 2'b01) begin n_err++; $display("FAIL rmb_own1: got gnt=%b cs=%b want gnt=1 cs=01", m1_gnt, spi_cs_n); end
    m1_txn_start = 1'b1; step; m1_txn_start = 1'b0; step;
    rst_n = 1'b0; step;
    n_cmp++; if (spi_cs_n !== 2'b11 || m1_gnt !== 1'b0 || m0_gnt !== 1'b0) begin n_err++; $display("FAIL rmb_reset: got cs=%b gnt=%b%b want cs=11 gnt=00", spi_cs_n, m1_gnt, m0_gnt); end
    m0_req = 1'b1; m1_req = 1'b1; m0_cs_n = 2'b10; rst_n = 1'b1;
    step; step; step;
    n_cmp++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_err++; $display("FAIL rmb_tie: got gnt=%b%b want 01", m1_gnt, m0_gnt); end
  endtask

  task automatic test_round_robin;
    logic ex;
    rst_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0; step;
    n_cmp++; if (fp_spi_cs_n !== 2'b11 || fp_m0_gnt !== 1'b0 || fp_protocol_err !== 1'b0) begin n_err++; $display("FAIL fp_reset: got cs=%b gnt=%b err=%b want 11 0 0", fp_spi_cs_n, fp_m0_gnt, fp_protocol_err); end
    m0_req = 1'b1; m1_req = 1'b1; m0_cs_n = 2'b10; m1_cs_n = 2'b01;
    m0_data_tx = 8'hA0; m1_data_tx = 8'hB1; rst_n = 1'b1;
    step; step; step;
    for (int i = 0; i < 4; i++) begin
      ex = (i % 2) == 1;
      n_cmp++; if (m1_gnt !== ex || m0_gnt !== !ex) begin n_err++; $display("FAIL rr_gnt%0d: got %b%b want %b%b", i, m1_gnt, m0_gnt, ex, !ex); end
      n_cmp++; if (fp_m0_gnt !== 1'b1 || fp_m1_gnt !== 1'b0) begin n_err++; $display("FAIL fp_gnt%0d: got %b%b want 01", i, fp_m1_gnt, fp_m0_gnt); end
      n_cmp++; if (spi_cs_n !== (ex ? 2'b01 : 2'b10)) begin n_err++; $display("FAIL rr_cs%0d: got %b want %b", i, spi_cs_n, ex ? 2'b01 : 2'b10); end
      m0_req = 1'b0; m1_req = 1'b0; m0_txn_start = 1'b1; m1_txn_start = 1'b1;
      #1;
      n_cmp++; if (spi_data_tx !== (ex ? 8'hB1 : 8'hA0)) begin n_err++; $display("FAIL rr_tx%0d: got %h want %h", i, spi_data_tx, ex ? 8'hB1 : 8'hA0); end
      n_cmp++; if (fp_spi_data_tx !== 8'hA0) begin n_err++; $display("FAIL fp_tx%0d: got %h want a0", i, fp_spi_data_tx); end
      step;
      m0_txn_start = 1'b0; m1_txn_start = 1'b0; spi_txn_done = 1'b1;
      #1;
      n_cmp++; if ((ex ? m1_txn_done : m0_txn_done) !== 1'b1 || (ex ? m0_txn_done : m1_txn_done) !== 1'b0) begin n_err++; $display("FAIL rr_done%0d: got %b%b want %b%b", i, m1_txn_done, m0_txn_done, ex, !ex); end
      step;
      spi_txn_done = 1'b0;
      step;
      n_cmp++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || spi_cs_n !== 2'b11) begin n_err++; $display("FAIL rr_gap%0d: got gnt=%b%b cs=%b want 00 11", i, m1_gnt, m0_gnt, spi_cs_n); end
      m0_req = 1'b1; m1_req = 1'b1;
      step; step; step;
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_late_release();
    test_protocol_err();
    test_reset_mid_burst();
    test_round_robin();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
